// File: rtl/snoop_bus_pkg.sv
// Shared types for the snoop bus responder: request opcodes, response codes
// and the responder FSM states.
package snoop_bus_pkg;

  // Request opcodes on the sdt channel; 3'b100..3'b111 are illegal.
  typedef enum logic [2:0] {
    OpRdS = 3'b000,
    OpRdX = 3'b001,
    OpInv = 3'b010,
    OpWb  = 3'b011
  } op_e;

  // Response codes on the sdr channel.
  typedef enum logic [2:0] {
    RspNone  = 3'b000,
    RspAck   = 3'b001,
    RspDataE = 3'b010,
    RspDataS = 3'b011,
    RspErr   = 3'b111
  } rsp_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StResp = 2'b10
  } state_e;

endpackage

// File: rtl/snoop_resp_mem.sv
// Block-granular backing store for the snoop bus responder.
// One synchronous write port, one combinational read port, async-reset to zero.
// Optional feature: SNOOP_RSP_SHARED_TRACK_EN adds a per-block shared bit.
module snoop_resp_mem
  import snoop_bus_pkg::*;
#(
  parameter int unsigned BLK_WIDTH = 32,
  parameter int unsigned NUM_BLK   = 16,
  parameter int unsigned IDX_WIDTH = $clog2(NUM_BLK)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [IDX_WIDTH-1:0] wr_idx,
  input  logic [BLK_WIDTH-1:0] wr_data,
  input  logic [IDX_WIDTH-1:0] rd_idx,
  output logic [BLK_WIDTH-1:0] rd_data
`ifdef SNOOP_RSP_SHARED_TRACK_EN
  ,
  input  logic                 sh_we,
  input  logic                 sh_wval,
  output logic                 sh_rd
`endif
);

  logic [BLK_WIDTH-1:0] mem_q [NUM_BLK];

  // Block storage: cleared on reset, written by accepted write-backs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_BLK); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_idx];

`ifdef SNOOP_RSP_SHARED_TRACK_EN
  logic [NUM_BLK-1:0] sh_q;

  // Shared bits share the read index: they are updated for the block being answered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= '0;
    end else if (sh_we) begin
      sh_q[rd_idx] <= sh_wval;
    end
  end

  assign sh_rd = sh_q[rd_idx];
`endif

endmodule

// File: rtl/snoop_bus_responder.sv
// Downstream responder for the cache sdt/sdr channel pair, backed by a small
// block memory. One request outstanding; response after RSP_LAT wait cycles.
// Optional feature: SNOOP_RSP_SHARED_TRACK_EN (RD_S returns DATA_S on re-read).
module snoop_bus_responder
  import snoop_bus_pkg::*;
#(
  parameter int unsigned PADDR_WIDTH = 16,
  parameter int unsigned BLK_WIDTH   = 32,
  parameter int unsigned NUM_BLK     = 16,
  parameter int unsigned RSP_LAT     = 2,
  parameter int unsigned SADDR_WIDTH = PADDR_WIDTH - $clog2(BLK_WIDTH / 8)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sdt_valid,
  output logic                   sdt_ready,
  input  logic [2:0]             sdt_op,
  input  logic [SADDR_WIDTH-1:0] sdt_addr,
  input  logic [BLK_WIDTH-1:0]   sdt_data,
  output logic                   sdr_valid,
  input  logic                   sdr_ready,
  output logic [2:0]             sdr_rsp,
  output logic [BLK_WIDTH-1:0]   sdr_data
);

  localparam int unsigned IdxW = $clog2(NUM_BLK);
  localparam int unsigned CntW = (RSP_LAT > 0) ? $clog2(RSP_LAT + 1) : 1;
  // WAIT lasts RSP_LAT cycles, so the counter starts one below the latency.
  localparam logic [CntW-1:0] CntLoad = CntW'((RSP_LAT == 0) ? 0 : RSP_LAT - 1);

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2:0]           op_q, op_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 ready_q, ready_d;
  rsp_e                 rsp_q, rsp_d;
  logic [BLK_WIDTH-1:0] data_q, data_d;

  logic [2:0]           cur_op;
  logic [IdxW-1:0]      cur_idx;
  logic                 accept;
  logic                 enter_resp;
  logic                 wr_en;
  logic [BLK_WIDTH-1:0] rd_data;
  rsp_e                 new_rsp;
  logic [BLK_WIDTH-1:0] new_data;

  if (SADDR_WIDTH > IdxW) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^sdt_addr[SADDR_WIDTH-1:IdxW];
  end

`ifdef SNOOP_RSP_SHARED_TRACK_EN
  logic sh_we;
  logic sh_wval;
  logic sh_rd;
`endif

  snoop_resp_mem #(
    .BLK_WIDTH (BLK_WIDTH),
    .NUM_BLK   (NUM_BLK),
    .IDX_WIDTH (IdxW)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_idx  (cur_idx),
    .wr_data (sdt_data),
    .rd_idx  (cur_idx),
    .rd_data (rd_data)
`ifdef SNOOP_RSP_SHARED_TRACK_EN
    ,
    .sh_we   (sh_we),
    .sh_wval (sh_wval),
    .sh_rd   (sh_rd)
`endif
  );

  // Next state, latches and counter; in IDLE the live request drives the memory
  // ports so a zero-latency response can be formed on the accept edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    idx_d      = idx_q;
    rsp_d      = rsp_q;
    data_d     = data_q;
    cur_op     = op_q;
    cur_idx    = idx_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    wr_en      = 1'b0;
    unique case (state_q)
      StIdle: begin
        cur_op  = sdt_op;
        cur_idx = sdt_addr[IdxW-1:0];
        accept  = sdt_valid && ready_q;
        if (accept) begin
          op_d  = cur_op;
          idx_d = cur_idx;
          wr_en = (cur_op == OpWb);
          if (RSP_LAT == 0) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = CntLoad;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        if (sdr_ready) begin
          state_d = StIdle;
          rsp_d   = RspNone;
          data_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (enter_resp) begin
      rsp_d  = new_rsp;
      data_d = new_data;
    end
    ready_d = (state_d == StIdle);
  end

  // Response decode for the request currently on the memory ports.
  always_comb begin
    new_rsp  = RspErr;
    new_data = '0;
`ifdef SNOOP_RSP_SHARED_TRACK_EN
    sh_we    = 1'b0;
    sh_wval  = 1'b0;
`endif
    case (cur_op)
      OpRdS: begin
        new_rsp  = RspDataE;
        new_data = rd_data;
`ifdef SNOOP_RSP_SHARED_TRACK_EN
        if (sh_rd) new_rsp = RspDataS;
        sh_we   = enter_resp;
        sh_wval = 1'b1;
`endif
      end
      OpRdX: begin
        new_rsp  = RspDataE;
        new_data = rd_data;
`ifdef SNOOP_RSP_SHARED_TRACK_EN
        sh_we    = enter_resp;
`endif
      end
      OpInv, OpWb: begin
        new_rsp = RspAck;
`ifdef SNOOP_RSP_SHARED_TRACK_EN
        sh_we   = enter_resp;
`endif
      end
      default: new_rsp = RspErr;
    endcase
  end

  // State and output registers; ready is registered so it stays low during reset
  // and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      idx_q   <= '0;
      ready_q <= 1'b0;
      rsp_q   <= RspNone;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      rsp_q   <= rsp_d;
      data_q  <= data_d;
    end
  end

  assign sdt_ready = ready_q;
  assign sdr_valid = (state_q == StResp);
  assign sdr_rsp   = rsp_q;
  assign sdr_data  = data_q;

endmodule

// File: tb/tb_snoop_bus_responder.sv
// Self-checking bench for snoop_bus_responder: directed vector table, hand
// sequences for back-pressure and mid-transaction reset, then random traffic
// against a behavioural memory model.
module tb_snoop_bus_responder;

  localparam int unsigned PW  = 16;
  localparam int unsigned BW  = 32;
  localparam int unsigned NB  = 16;
  localparam int unsigned LAT = 2;
  localparam int unsigned SW  = PW - $clog2(BW / 8);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sdt_valid;
  logic          sdt_ready;
  logic [2:0]    sdt_op;
  logic [SW-1:0] sdt_addr;
  logic [BW-1:0] sdt_data;
  logic          sdr_valid;
  logic          sdr_ready;
  logic [2:0]    sdr_rsp;
  logic [BW-1:0] sdr_data;

  int nvec = 0;
  int nmis = 0;

  // Reference state: plain arrays indexed by block number.
  logic [BW-1:0] mmem [NB];
  logic          msh  [NB];

  snoop_bus_responder #(
    .PADDR_WIDTH (PW),
    .BLK_WIDTH   (BW),
    .NUM_BLK     (NB),
    .RSP_LAT     (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sdt_valid (sdt_valid),
    .sdt_ready (sdt_ready),
    .sdt_op    (sdt_op),
    .sdt_addr  (sdt_addr),
    .sdt_data  (sdt_data),
    .sdr_valid (sdr_valid),
    .sdr_ready (sdr_ready),
    .sdr_rsp   (sdr_rsp),
    .sdr_data  (sdr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(NB); i++) begin
      mmem[i] = '0;
      msh[i]  = 1'b0;
    end
  endtask

  // Behavioural effect of one request: returns the expected response and data.
  task automatic model(input logic [2:0] op, input logic [SW-1:0] addr, input logic [BW-1:0] wd,
                       output logic [2:0] rsp, output logic [BW-1:0] d);
    int idx;
    idx = int'(addr) % int'(NB);
    rsp = 3'b111;
    d   = '0;
    case (op)
      3'd0: begin
        d   = mmem[idx];
        rsp = 3'b010;
`ifdef SNOOP_RSP_SHARED_TRACK_EN
        if (msh[idx]) rsp = 3'b011;
        msh[idx] = 1'b1;
`endif
      end
      3'd1: begin
        d   = mmem[idx];
        rsp = 3'b010;
        msh[idx] = 1'b0;
      end
      3'd2: begin
        rsp = 3'b001;
        msh[idx] = 1'b0;
      end
      3'd3: begin
        mmem[idx] = wd;
        rsp = 3'b001;
        msh[idx] = 1'b0;
      end
      default: rsp = 3'b111;
    endcase
  endtask

  // One full transaction. Inputs are driven and outputs sampled 1 time unit
  // after the rising edge. busy drives a second request during the hold phase.
  task automatic do_txn(input string tag, input logic [2:0] op, input logic [SW-1:0] addr,
                        input logic [BW-1:0] wd, input int hold, input bit early,
                        input bit busy, input logic [2:0] exp_rsp, input logic [BW-1:0] exp_d);
    int k;
    k = 0;
    while (!sdt_ready && k < 20) begin
      @(posedge clk); #1; k++;
    end
    chk({tag, " ready_before_req"}, 64'(sdt_ready), 64'(1));
    sdt_valid = 1'b1;
    sdt_op    = op;
    sdt_addr  = addr;
    sdt_data  = wd;
    @(posedge clk); #1;
    sdt_valid = 1'b0;
    sdr_ready = early;
    chk({tag, " ready_low_after_accept"}, 64'(sdt_ready), 64'(0));
    k = 0;
    while (!sdr_valid && k < int'(LAT) + 10) begin
      @(posedge clk); #1; k++;
    end
    chk({tag, " latency"}, 64'(k), 64'(LAT));
    chk({tag, " rsp"}, 64'(sdr_rsp), 64'(exp_rsp));
    chk({tag, " data"}, 64'(sdr_data), 64'(exp_d));
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        if (busy) begin
          sdt_valid = 1'b1;
          sdt_op    = 3'b001;
          sdt_addr  = SW'(2);
        end
        @(posedge clk); #1;
        chk({tag, " hold_valid"}, 64'(sdr_valid), 64'(1));
        chk({tag, " hold_rsp"}, 64'(sdr_rsp), 64'(exp_rsp));
        chk({tag, " hold_data"}, 64'(sdr_data), 64'(exp_d));
        chk({tag, " hold_sdt_ready"}, 64'(sdt_ready), 64'(0));
      end
    end
    sdr_ready = 1'b1;
    @(posedge clk); #1;
    sdr_ready = 1'b0;
    chk({tag, " valid_drop"}, 64'(sdr_valid), 64'(0));
    chk({tag, " ready_rise"}, 64'(sdt_ready), 64'(1));
  endtask

  typedef struct {
    logic [2:0]    op;
    logic [SW-1:0] addr;
    logic [BW-1:0] wd;
    int            hold;
    logic [2:0]    rsp;
    logic [BW-1:0] d;
  } vec_t;

  localparam logic [2:0] ExpRdS2 =
`ifdef SNOOP_RSP_SHARED_TRACK_EN
    3'b011;
`else
    3'b010;
`endif

  vec_t tbl [12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]    mr;
    logic [BW-1:0] md;
    logic [2:0]    rop;
    logic [SW-1:0] raddr;
    logic [BW-1:0] rwd;
    int            r;
    int            rh;
    bit            re;

    tbl[0]  = '{3'b001, SW'('h005),  32'h0,        2, 3'b010,  32'h0};
    tbl[1]  = '{3'b011, SW'('h003),  32'hDEADBEEF, 0, 3'b001,  32'h0};
    tbl[2]  = '{3'b001, SW'('h003),  32'h0,        1, 3'b010,  32'hDEADBEEF};
    tbl[3]  = '{3'b001, SW'('h013),  32'h0,        0, 3'b010,  32'hDEADBEEF};
    tbl[4]  = '{3'b000, SW'('h007),  32'h0,        0, 3'b010,  32'h0};
    tbl[5]  = '{3'b000, SW'('h007),  32'h0,        0, ExpRdS2, 32'h0};
    tbl[6]  = '{3'b010, SW'('h007),  32'h0,        0, 3'b001,  32'h0};
    tbl[7]  = '{3'b000, SW'('h007),  32'h0,        0, 3'b010,  32'h0};
    tbl[8]  = '{3'b101, SW'('h003),  32'h12345678, 1, 3'b111,  32'h0};
    tbl[9]  = '{3'b001, SW'('h003),  32'h0,        0, 3'b010,  32'hDEADBEEF};
    tbl[10] = '{3'b011, SW'('h3FFF), 32'hA5A5A5A5, 0, 3'b001,  32'h0};
    tbl[11] = '{3'b000, SW'('h000F), 32'h0,        0, 3'b010,  32'hA5A5A5A5};

    rst_n     = 1'b0;
    sdt_valid = 1'b0;
    sdt_op    = '0;
    sdt_addr  = '0;
    sdt_data  = '0;
    sdr_ready = 1'b0;
    model_clear();

    // Reset values, then ready rises one edge after release.
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset sdt_ready", 64'(sdt_ready), 64'(0));
    chk("reset sdr_valid", 64'(sdr_valid), 64'(0));
    chk("reset sdr_rsp", 64'(sdr_rsp), 64'(0));
    chk("reset sdr_data", 64'(sdr_data), 64'(0));
    rst_n = 1'b1;
    #1;
    chk("ready_low_at_release", 64'(sdt_ready), 64'(0));
    @(posedge clk); #1;
    chk("ready_first_cycle", 64'(sdt_ready), 64'(1));

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      model(tbl[i].op, tbl[i].addr, tbl[i].wd, mr, md);
      do_txn($sformatf("vec%0d", i), tbl[i].op, tbl[i].addr, tbl[i].wd, tbl[i].hold, 1'b0,
             1'b0, tbl[i].rsp, tbl[i].d);
    end

    // Back-pressure: a second request waits until one cycle after the handshake.
    model(3'b011, SW'(9), 32'h0BADF00D, mr, md);
    do_txn("bp_wb", 3'b011, SW'(9), 32'h0BADF00D, 0, 1'b0, 1'b0, mr, md);
    model(3'b001, SW'(9), 32'h0, mr, md);
    do_txn("bp_rd", 3'b001, SW'(9), 32'h0, 5, 1'b0, 1'b1, mr, md);
    model(3'b001, SW'(2), 32'h0, mr, md);
    do_txn("bp_second", 3'b001, SW'(2), 32'h0, 0, 1'b0, 1'b0, mr, md);

    // Early sdr_ready before valid is harmless.
    model(3'b001, SW'(9), 32'h0, mr, md);
    do_txn("early_rdy", 3'b001, SW'(9), 32'h0, 0, 1'b1, 1'b0, mr, md);

    // Reset during WAIT after a write-back discards the write.
    sdt_valid = 1'b1;
    sdt_op    = 3'b011;
    sdt_addr  = SW'('h00A);
    sdt_data  = 32'hCAFEF00D;
    @(posedge clk); #1;
    sdt_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrst in_wait", 64'(sdr_valid), 64'(0));
    rst_n = 1'b0;
    #1;
    chk("midrst sdt_ready", 64'(sdt_ready), 64'(0));
    chk("midrst sdr_valid", 64'(sdr_valid), 64'(0));
    chk("midrst sdr_rsp", 64'(sdr_rsp), 64'(0));
    chk("midrst sdr_data", 64'(sdr_data), 64'(0));
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst ready_after", 64'(sdt_ready), 64'(1));
    model(3'b001, SW'('h00A), 32'h0, mr, md);
    do_txn("midrst_rd", 3'b001, SW'('h00A), 32'h0, 0, 1'b0, 1'b0, mr, md);

    // Random traffic against the model; low 4 address bits drawn from a small
    // range to force block reuse.
    for (int n = 0; n < 80; n++) begin
      r = int'($urandom_range(0, 9));
      rop = (r < 8) ? 3'(r % 4) : 3'($urandom_range(4, 7));
      raddr = SW'({$urandom_range(0, 1023), 4'($urandom_range(0, 5))});
      rwd = $urandom;
      re = ($urandom_range(0, 3) == 0);
      rh = re ? 0 : int'($urandom_range(0, 3));
      model(rop, raddr, rwd, mr, md);
      do_txn($sformatf("rnd%0d", n), rop, raddr, rwd, rh, re, 1'b0, mr, md);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
